lights_sequencer: RTL and testbench

LIGHTS_SEQUENCER -- requirements
Module: lights_sequencer

---
 rtl/lights_pkg.sv | 32 +++
 rtl/btn_debounce.sv | 41 ++++
 rtl/lights_sequencer.sv | 84 ++++++++
 tb/tb_lights_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lights_pkg.sv
// Shared encodings and defaults for the lights sequencer and its button front end.
package lights_pkg;

  localparam int CNT_W_DEF      = 16;
  localparam int DEB_CYCLES_DEF = 4;

  typedef enum logic [1:0] {
    MODE_WHITE  = 2'b00,
    MODE_MANUAL = 2'b01,
    MODE_AUTO   = 2'b10,
    MODE_FREEZE = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    S_WHITE  = 2'b00,
    S_MANUAL = 2'b01,
    S_AUTO   = 2'b10,
    S_FREEZE = 2'b11
  } state_e;

  function automatic state_e mode_to_state(input logic [1:0] m);
    state_e s;
    case (mode_e'(m))
      MODE_MANUAL: s = S_MANUAL;
      MODE_AUTO:   s = S_AUTO;
      MODE_FREEZE: s = S_FREEZE;
      default:     s = S_WHITE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a stability debouncer for a bouncy push-button.
module btn_debounce
  import lights_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int              DC_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DC_W-1:0] DC_LAST = DC_W'(DEB_CYCLES - 1);

  logic            sync_p0;
  logic            sync_p1;
  logic [DC_W-1:0] deb_cnt;

  // Any sample that matches the accepted level restarts the stability window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      deb_cnt <= '0;
      dout    <= 1'b0;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
      if (sync_p1 == dout) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DC_LAST) begin
        dout    <= sync_p1;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/lights_sequencer.sv
// Mode FSM, auto-step prescaler and step counter driving a lights selector.
module lights_sequencer
  import lights_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] period,
  input  logic             btn_raw,
  output logic             sel,
  output logic             step,
  output logic [7:0]       step_count
);

  state_e           state_q;
  state_e           state_nxt;
  logic             btn_clean;
  logic             btn_prev;
  logic             btn_rise;
  logic             mode_hold;
  logic [CNT_W-1:0] presc_q;
  logic [CNT_W-1:0] presc_nxt;
  logic [CNT_W-1:0] presc_last;
  logic             presc_done;
  logic             step_nxt;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_btn_debounce (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (btn_raw),
    .dout (btn_clean)
  );

  // A pending step is dropped whenever the mode is about to change; the
  // prescaler stays at zero outside AUTO so every entry starts a fresh period.
  always_comb begin
    state_nxt  = mode_to_state(mode);
    mode_hold  = (state_nxt == state_q);
    btn_rise   = btn_clean & ~btn_prev;
    presc_last = (period == '0) ? '0 : period - 1'b1;
    presc_done = (presc_q >= presc_last);
    presc_nxt  = '0;
    step_nxt   = 1'b0;
    case (state_q)
      S_MANUAL: step_nxt = mode_hold & btn_rise;
      S_AUTO: begin
        if (mode_hold) begin
          if (presc_done) begin
            step_nxt = 1'b1;
          end else begin
            presc_nxt = presc_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_WHITE;
      sel        <= 1'b0;
      step       <= 1'b0;
      step_count <= '0;
      presc_q    <= '0;
      btn_prev   <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      sel      <= (state_q != S_WHITE);
      step     <= step_nxt;
      presc_q  <= presc_nxt;
      btn_prev <= btn_clean;
      if (step_nxt) begin
        step_count <= step_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_lights_sequencer.sv
// Scoreboard bench for lights_sequencer: expected step pulses are queued as stimulus is applied.
module tb_lights_sequencer;

  logic        clk;
  logic        rst_n;
  logic [1:0]  mode;
  logic [15:0] period;
  logic        btn_raw;
  logic        sel;
  logic        step;
  logic [7:0]  step_count;

  typedef struct {
    int         rel;
    logic [7:0] cnt;
  } pulse_t;

  pulse_t     exp_q[$];
  pulse_t     e;
  logic [7:0] model_cnt;
  int         checks;
  int         failures;

  lights_sequencer #(
    .CNT_W     (16),
    .DEB_CYCLES(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .period    (period),
    .btn_raw   (btn_raw),
    .sel       (sel),
    .step      (step),
    .step_count(step_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_pulse(input int rel);
    pulse_t p;
    model_cnt = model_cnt + 8'd1;
    p.rel = rel;
    p.cnt = model_cnt;
    exp_q.push_back(p);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mode = 2'b10; period = 16'd5; btn_raw = 1'b0;
    for (int i = 0; i < 5; i++) @(negedge clk);
    checks++;
    if (sel !== 1'b0) begin failures++; $display("FAIL reset_sel got=%b exp=0", sel); end
    checks++;
    if (step !== 1'b0) begin failures++; $display("FAIL reset_step got=%b exp=0", step); end
    checks++;
    if (step_count !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", step_count); end
    rst_n = 1'b1;
    model_cnt = 8'd0;
    for (int rel = 1; rel <= 4; rel++) begin
      if (rel == 3) mode = 2'b00;
      @(negedge clk);
      if (rel == 1) begin
        checks++;
        if (sel !== 1'b0 || step !== 1'b0 || step_count !== 8'd0) begin
          failures++; $display("FAIL reset_release sel=%b step=%b count=%0d exp 0/0/0", sel, step, step_count);
        end
      end
      if (rel == 2) begin
        checks++;
        if (sel !== 1'b1) begin failures++; $display("FAIL reset_sel_auto got=%b exp=1", sel); end
      end
      if (rel == 4) begin
        checks++;
        if (sel !== 1'b0) begin failures++; $display("FAIL reset_sel_white got=%b exp=0", sel); end
      end
    end
  endtask

  task automatic test_auto();
    for (int rel = 1; rel <= 72; rel++) begin
      if (rel == 1) begin
        mode = 2'b10; period = 16'd5;
        for (int k = 0; k < 10; k++) push_pulse(6 + 5 * k);
      end
      if (rel == 53) begin
        period = 16'd0;
        for (int k = 53; k <= 60; k++) push_pulse(k);
      end
      if (rel == 61) period = 16'd10;
      if (rel == 67) begin
        period = 16'd3;
        push_pulse(67);
        push_pulse(70);
      end
      @(negedge clk);
      if (step !== 1'b0) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL auto_pulse rel=%0d step=%b expected no step", rel, step);
        end else begin
          e = exp_q.pop_front();
          if (e.rel != rel || step_count !== e.cnt) begin
            failures++; $display("FAIL auto_pulse rel=%0d count=%0d expected rel=%0d count=%0d", rel, step_count, e.rel, e.cnt);
          end
        end
      end
      if (rel == 52) begin
        checks++;
        if (step_count !== 8'd10) begin failures++; $display("FAIL auto_count10 got=%0d exp=10", step_count); end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL auto_missing left=%0d exp=0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_manual();
    for (int rel = 1; rel <= 170; rel++) begin
      if (rel == 1) begin mode = 2'b01; btn_raw = 1'b0; end
      if (rel >= 4 && rel <= 13) btn_raw = ~btn_raw;
      if (rel == 14) begin btn_raw = 1'b1; push_pulse(20); end
      if (rel == 121) btn_raw = 1'b0;
      if (rel == 136) mode = 2'b00;
      if (rel == 138) btn_raw = 1'b1;
      if (rel == 150) mode = 2'b01;
      @(negedge clk);
      if (step !== 1'b0) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL manual_pulse rel=%0d step=%b expected no step", rel, step);
        end else begin
          e = exp_q.pop_front();
          if (e.rel != rel || step_count !== e.cnt) begin
            failures++; $display("FAIL manual_pulse rel=%0d count=%0d expected rel=%0d count=%0d", rel, step_count, e.rel, e.cnt);
          end
        end
      end
      if (rel == 120) begin
        checks++;
        if (step_count !== model_cnt) begin failures++; $display("FAIL manual_hold_count got=%0d exp=%0d", step_count, model_cnt); end
      end
      if (rel == 140) begin
        checks++;
        if (sel !== 1'b0) begin failures++; $display("FAIL manual_white_sel got=%b exp=0", sel); end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL manual_missing left=%0d exp=0", exp_q.size()); end
    exp_q.delete();
    btn_raw = 1'b0;
  endtask

  task automatic test_priority();
    for (int rel = 1; rel <= 20; rel++) begin
      if (rel == 1) begin mode = 2'b10; period = 16'd5; push_pulse(6); end
      if (rel == 11) mode = 2'b11;
      @(negedge clk);
      if (step !== 1'b0) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL prio_pulse rel=%0d step=%b expected no step", rel, step);
        end else begin
          e = exp_q.pop_front();
          if (e.rel != rel || step_count !== e.cnt) begin
            failures++; $display("FAIL prio_pulse rel=%0d count=%0d expected rel=%0d count=%0d", rel, step_count, e.rel, e.cnt);
          end
        end
      end
      if (rel >= 11) begin
        checks++;
        if (sel !== 1'b1) begin failures++; $display("FAIL prio_sel rel=%0d got=%b exp=1", rel, sel); end
      end
    end
    checks++;
    if (step_count !== model_cnt) begin failures++; $display("FAIL prio_count got=%0d exp=%0d", step_count, model_cnt); end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL prio_missing left=%0d exp=0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_midreset();
    for (int rel = 1; rel <= 14; rel++) begin
      if (rel == 1) begin mode = 2'b10; period = 16'd5; end
      if (rel == 5) begin
        rst_n = 1'b0;
        #1;
        checks++;
        if (sel !== 1'b0 || step !== 1'b0 || step_count !== 8'd0) begin
          failures++; $display("FAIL midreset_clear sel=%b step=%b count=%0d exp 0/0/0", sel, step, step_count);
        end
        model_cnt = 8'd0;
      end
      if (rel == 6) begin rst_n = 1'b1; push_pulse(11); end
      @(negedge clk);
      if (step !== 1'b0) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL midreset_pulse rel=%0d step=%b expected no step", rel, step);
        end else begin
          e = exp_q.pop_front();
          if (e.rel != rel || step_count !== e.cnt) begin
            failures++; $display("FAIL midreset_pulse rel=%0d count=%0d expected rel=%0d count=%0d", rel, step_count, e.rel, e.cnt);
          end
        end
      end
      if (rel == 6) begin
        checks++;
        if (sel !== 1'b0) begin failures++; $display("FAIL midreset_white got=%b exp=0", sel); end
      end
      if (rel == 7) begin
        checks++;
        if (sel !== 1'b1) begin failures++; $display("FAIL midreset_auto got=%b exp=1", sel); end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL midreset_missing left=%0d exp=0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_wrap();
    for (int rel = 1; rel <= 262; rel++) begin
      if (rel == 1) begin
        rst_n = 1'b0; mode = 2'b10; period = 16'd1;
        model_cnt = 8'd0;
      end
      if (rel == 3) begin
        rst_n = 1'b1;
        for (int k = 4; k <= 259; k++) push_pulse(k);
      end
      if (rel == 260) mode = 2'b11;
      @(negedge clk);
      if (step !== 1'b0) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL wrap_pulse rel=%0d step=%b expected no step", rel, step);
        end else begin
          e = exp_q.pop_front();
          if (e.rel != rel || step_count !== e.cnt) begin
            failures++; $display("FAIL wrap_pulse rel=%0d count=%0d expected rel=%0d count=%0d", rel, step_count, e.rel, e.cnt);
          end
        end
      end
    end
    checks++;
    if (step_count !== 8'd0) begin failures++; $display("FAIL wrap_count got=%0d exp=0", step_count); end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL wrap_missing left=%0d exp=0", exp_q.size()); end
    exp_q.delete();
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    model_cnt = 8'd0;
    rst_n     = 1'b0;
    mode      = 2'b10;
    period    = 16'd5;
    btn_raw   = 1'b0;
    test_reset();
    test_auto();
    test_manual();
    test_priority();
    test_midreset();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
